// File: rtl/berger_pkg.sv
// Shared defaults and FSM state encoding for the Berger fault-injection campaign.
package berger_pkg;
    localparam int BERGER_DATA_W = 8;
    localparam int BERGER_CODE_W = 12;
    localparam int BERGER_ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ADDR,
        S_RD_SAMPLE,
        S_DONE
    } state_e;
endpackage

// File: rtl/berger_pattern_gen.sv
// Expected memory contents for an address: seed XOR the address replicated across the word.
module berger_pattern_gen #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic [DATA_W-1:0] seed_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] exp_o
);
    logic [DATA_W-1:0] rep;

    // {a, a, ...} truncated to DATA_W keeps the low bits, so bit i is a[i mod ADDR_W]
    always_comb begin
        rep = '0;
        for (int i = 0; i < DATA_W; i++) rep[i] = addr_i[i % ADDR_W];
    end

    assign exp_o = seed_i ^ rep;
endmodule

// File: rtl/berger_fault_campaign.sv
// Fill-then-read campaign against the Berger faulty memory, grading each read
// as detected, undetected (silent corruption) or clean.
module berger_fault_campaign
    import berger_pkg::*;
#(
    parameter int DATA_W = BERGER_DATA_W,
    parameter int CODE_W = BERGER_CODE_W,
    parameter int ADDR_W = BERGER_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] pattern_seed_i,
    input  logic [CODE_W-1:0] fault_mask_cfg_i,
    input  logic              fault_zero_to_one_cfg_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wr_en_o,
    output logic [CODE_W-1:0] mem_fault_mask_o,
    output logic              mem_fault_enable_o,
    output logic              mem_fault_zero_to_one_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    input  logic              mem_err_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   detected_cnt_o,
    output logic [ADDR_W:0]   undetected_cnt_o,
    output logic [ADDR_W:0]   clean_cnt_o,
    output logic [ADDR_W-1:0] first_undetected_addr_o,
    output logic              first_undetected_valid_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] seed_q;
    logic [CODE_W-1:0] mask_q;
    logic              dir_q;
    logic [ADDR_W:0]   det_q, und_q, cln_q;
    logic [ADDR_W-1:0] first_addr_q;
    logic              first_vld_q;

    logic [DATA_W-1:0] exp_data;
    logic              rd_mismatch;
    logic              in_wr, in_rd;

    // One generator serves both phases: cnt_q is the write address and the read address.
    berger_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pattern (
        .seed_i (seed_q),
        .addr_i (cnt_q),
        .exp_o  (exp_data)
    );

    assign rd_mismatch = (mem_rd_data_i != exp_data);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            seed_q       <= '0;
            mask_q       <= '0;
            dir_q        <= 1'b0;
            det_q        <= '0;
            und_q        <= '0;
            cln_q        <= '0;
            first_addr_q <= '0;
            first_vld_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        seed_q       <= pattern_seed_i;
                        mask_q       <= fault_mask_cfg_i;
                        dir_q        <= fault_zero_to_one_cfg_i;
                        det_q        <= '0;
                        und_q        <= '0;
                        cln_q        <= '0;
                        first_addr_q <= '0;
                        first_vld_q  <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_q   <= '0;
                        state_q <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: state_q <= S_RD_SAMPLE;
                S_RD_SAMPLE: begin
                    // An error flag wins even when the data happens to match.
                    if (mem_err_i) begin
                        det_q <= det_q + 1'b1;
                    end else if (rd_mismatch) begin
                        und_q <= und_q + 1'b1;
                        if (!first_vld_q) begin
                            first_addr_q <= cnt_q;
                            first_vld_q  <= 1'b1;
                        end
                    end else begin
                        cln_q <= cln_q + 1'b1;
                    end
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= S_RD_ADDR;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory-side outputs are pure decodes of registered state, zero outside their phase.
    always_comb begin
        in_wr = (state_q == S_WRITE);
        in_rd = (state_q == S_RD_ADDR) || (state_q == S_RD_SAMPLE);

        mem_wr_en_o             = in_wr;
        mem_addr_o              = (in_wr || in_rd) ? cnt_q : '0;
        mem_data_o              = in_wr ? exp_data : '0;
        mem_fault_enable_o      = in_rd;
        mem_fault_mask_o        = in_rd ? mask_q : '0;
        mem_fault_zero_to_one_o = in_rd ? dir_q : 1'b0;
        busy_o                  = in_wr || in_rd;
        done_o                  = (state_q == S_DONE);
    end

    assign detected_cnt_o           = det_q;
    assign undetected_cnt_o         = und_q;
    assign clean_cnt_o              = cln_q;
    assign first_undetected_addr_o  = first_addr_q;
    assign first_undetected_valid_o = first_vld_q;
endmodule

// File: doc/berger_fault_campaign.md
# berger_fault_campaign

Sequential test controller that drives the Berger-coded faulty memory and grades its read-back. On `start` it fills all memory locations with a deterministic pattern, then reads each location back with the configured unidirectional fault injected. Each read is classified as detected, undetected (silent corruption) or clean, and the controller reports the counts. It sits directly upstream of the faulty-memory block, driving its write/address/fault inputs, and consumes that block's `output_data` and `error_detected`.

## Interface
- `DATA_W`, 8: data word width.
- `CODE_W`, 12: codeword width, equal to `DATA_W` + 4 check bits. Sets the fault-mask width.
- `ADDR_W`, 4: address width. Depth = 2^`ADDR_W` = 16.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  campaign request; sampled in `IDLE` only.
- `pattern_seed`  in  DATA_W  pattern base; latched at start.
- `fault_mask_cfg`  in  CODE_W  fault mask for the read phase; latched at start.
- `fault_zero_to_one_cfg`  in  1  fault direction; latched at start.
- `mem_data`  out  DATA_W  write data to the memory block.
- `mem_addr`  out  ADDR_W  address to the memory block.
- `mem_wr_en`  out  1  write enable to the memory block.
- `mem_fault_mask`  out  CODE_W  drives `unidirectional_fault_mask`.
- `mem_fault_enable`  out  1  drives `fault_enable`.
- `mem_fault_zero_to_one`  out  1  drives `fault_zero_to_one`.
- `mem_rd_data`  in  DATA_W  memory `output_data`.
- `mem_err`  in  1  memory `error_detected`.
- `busy`  out  1  campaign in progress.
- `done`  out  1  one-cycle completion pulse.
- `detected_cnt`, `undetected_cnt`, `clean_cnt`  out  ADDR_W+1 each  per-class read counts.
- `first_undetected_addr`  out  ADDR_W  lowest address that read back undetected.
- `first_undetected_valid`  out  1  `first_undetected_addr` holds a valid address.

## Operation
- Expected data for address a: `exp(a) = pattern_seed_q ^ {a, a}`, where {a, a} is a replicated and truncated to `DATA_W` bits.
- FSM states: `IDLE`, `WRITE`, `RD_ADDR`, `RD_SAMPLE`, `DONE`.
  - `IDLE`: if `start`=1, latch the config inputs, clear all counts and `first_undetected_valid`, set the address counter to 0, and go to `WRITE`.
  - `WRITE`:
    - Drive `mem_wr_en`=1, `mem_addr`=cnt and `mem_data`=exp(cnt); `mem_fault_enable`=0.
    - cnt increments each cycle.
    - After address 2^ADDR_W−1, reset cnt to 0 and go to `RD_ADDR`.
  - `RD_ADDR`: drive `mem_addr`=cnt, `mem_wr_en`=0, `mem_fault_enable`=1, and the latched mask and direction. Go to `RD_SAMPLE`.
  - `RD_SAMPLE`:
    - Hold the same outputs as `RD_ADDR`.
    - Sample `mem_rd_data` and `mem_err`, then classify the read:
      - `mem_err`=1: increment `detected_cnt`. This applies even when the data matches expected.
      - `mem_err`=0 and data ≠ exp(cnt): increment `undetected_cnt`. If `first_undetected_valid`=0, capture cnt and set valid.
      - `mem_err`=0 and data = exp(cnt): increment `clean_cnt`.
    - If cnt is the last address, go to `DONE`. Otherwise increment cnt and go to `RD_ADDR`.
  - `DONE`: `done`=1 for one cycle, then go to `IDLE`.
- Invariant at `done`: `detected_cnt` + `undetected_cnt` + `clean_cnt` = 2^ADDR_W. Counter width ADDR_W+1 cannot overflow, so no saturation logic is needed.
- Results hold after `done` until the next accepted `start` or reset.
- `start` outside `IDLE` is ignored. Config input changes after the start edge have no effect.

## Timing
- Reset (`rst`=0 at an edge) forces state `IDLE` and sets every output to 0. This holds mid-campaign too: write enable drops in the same cycle and results are lost.
- E0 is the edge at which `start` is sampled in `IDLE`.
- `busy`=1 from E0 to the edge ending the last `RD_SAMPLE`.
- Write phase: `mem_wr_en`=1 for 16 cycles. The writes land at edges E1..E16.
- Read phase: 32 cycles, 2 per address. Read data is sampled one full cycle after its address is presented.
- `done`=1 in the cycle after E48. In that cycle `busy`=0 and the counts are final.
- The next `start` is accepted at the earliest in the cycle after `done`, when the FSM is back in `IDLE`.
- Outside the read phase, `mem_fault_enable`=0 and `mem_fault_mask`=0.

## Structure
- Shared package `berger_pkg` holds the `DATA_W`/`CODE_W`/`ADDR_W` defaults and the FSM state enum.
- One sub-module: `berger_pattern_gen`, combinational (seed, addr) → expected data. It is used by both the write drive and the read compare.
- The faulty-memory block is instantiated only in the testbench, wired port to port.

## Test plan
- Seed 0x3C, `fault_enable` path active with mask 0x000 → `clean_cnt`=16, other counts 0, `first_undetected_valid`=0, `done` pulse in the cycle after E48.
- Seed 0x00, mask 0xFFF, zero_to_one=1 → every codeword is forced to all-ones, which is always a Berger violation. Expect `detected_cnt`=16, `undetected_cnt`=0.
- Behavioral memory stub returning exp(a)^0x01 with `mem_err`=0 at addresses 5 and 9 only → `undetected_cnt`=2, `first_undetected_addr`=5, valid=1, `clean_cnt`=14.
- Check the write phase: during it, `mem_wr_en`=1 for exactly 16 cycles, addresses 0..15 in order, with `mem_data`=seed^{a,a} (seed 0xA5, addr 3 → 0x96).
- `start` re-pulsed during the write phase → ignored; single `done`, counts unchanged vs. the uninterrupted run.
- Reset asserted in `RD_SAMPLE` of address 7 → next cycle all outputs 0, FSM idle; a fresh `start` completes normally.
